// File: rtl/convolution_line_accumulator.sv
// Sums K_LINES consecutive signed line partial sums into one pixel, saturates it
// to O_SAT bits and queues it in a small valid/ready output FIFO.
module convolution_line_accumulator #(
  parameter int I_PSUM  = 19,
  parameter int K_LINES = 5,
  parameter int ACC     = 22,
  parameter int O_SAT   = 16,
  parameter int DEPTH   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_clear,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic signed [I_PSUM-1:0]      i_psum,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic signed [O_SAT-1:0]       o_data,
  output logic [$clog2(DEPTH):0]        o_count,
  output logic [$clog2(K_LINES)-1:0]    o_line,
  output logic                          o_sat
);

  localparam int LINE_W = $clog2(K_LINES);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_LAST  = 1'b1;

  logic signed [ACC-1:0]   r_acc;
  logic [LINE_W-1:0]       r_line;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic signed [O_SAT-1:0] r_mem [DEPTH];
  logic                    r_sat;

  logic signed [ACC-1:0]   w_ext;
  logic signed [ACC-1:0]   w_sum;
  logic [0:0]              w_state;
  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;

  // A value fits O_SAT bits when all bits from the O_SAT sign bit upward agree.
  function automatic logic is_clip(input logic signed [ACC-1:0] v);
    return !((&v[ACC-1:O_SAT-1]) || !(|v[ACC-1:O_SAT-1]));
  endfunction

  function automatic logic signed [O_SAT-1:0] sat(input logic signed [ACC-1:0] v);
    if (!is_clip(v))
      return v[O_SAT-1:0];
    else if (v[ACC-1])
      return {1'b1, {(O_SAT-1){1'b0}}};
    else
      return {1'b0, {(O_SAT-1){1'b1}}};
  endfunction

  always_comb begin
    w_ext    = {{(ACC-I_PSUM){i_psum[I_PSUM-1]}}, i_psum};
    w_sum    = r_acc + w_ext;
    w_state  = (r_line == LINE_W'(K_LINES-1)) ? ST_LAST : ST_ACCUM;
    w_accept = i_valid && o_ready;
    // A beat accepted together with i_clear is consumed but never completes a pixel.
    w_push   = w_accept && !i_clear && (w_state == ST_LAST);
    w_pop    = o_valid && i_ready;
  end

  assign o_ready = (r_count != CNT_W'(DEPTH));
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_line  = r_line;
  assign o_sat   = r_sat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_line <= '0;
    end else if (i_clear) begin
      r_acc  <= '0;
      r_line <= '0;
    end else if (w_accept) begin
      case (w_state)
        ST_ACCUM: begin
          r_acc  <= w_sum;
          r_line <= r_line + LINE_W'(1);
        end
        ST_LAST: begin
          r_acc  <= '0;
          r_line <= '0;
        end
        default: begin
          r_acc  <= '0;
          r_line <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_sat    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= sat(w_sum);
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        if (is_clip(w_sum)) r_sat <= 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_convolution_line_accumulator.sv
// Directed bench for convolution_line_accumulator: grouping, saturation, FIFO
// backpressure, clear and asynchronous reset.
module tb_convolution_line_accumulator;

  localparam int I_PSUM = 19;

  logic                     i_clk = 1'b0;
  logic                     i_rst_n;
  logic                     i_clear;
  logic                     i_valid;
  logic                     o_ready;
  logic signed [I_PSUM-1:0] i_psum;
  logic                     o_valid;
  logic                     i_ready;
  logic signed [15:0]       o_data;
  logic [2:0]               o_count;
  logic [2:0]               o_line;
  logic                     o_sat;

  int errors = 0;
  int checks = 0;

  convolution_line_accumulator dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_clear),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_psum  (i_psum),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_count (o_count),
    .o_line  (o_line),
    .o_sat   (o_sat)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic beat(input int p);
    i_valid = 1'b1;
    i_psum  = I_PSUM'(p);
    tick();
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_clear = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_psum  = '0;
    #12;
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
    checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    checks++; if (o_line !== 3'd0) begin errors++; $display("FAIL reset_line got=%0d exp=0", o_line); end
    checks++; if (o_data !== 16'sd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", o_data); end
    checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got=%0b exp=0", o_sat); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", o_ready); end
  endtask

  task automatic test_basic();
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat(5000);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%0b exp=0", o_valid); end
    beat(5000);
    i_valid = 1'b0;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b exp=1", o_valid); end
    checks++; if (o_data !== 16'sd25000) begin errors++; $display("FAIL basic_data got=%0d exp=25000", o_data); end
    checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL basic_sat got=%0b exp=0", o_sat); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_popped got=%0b exp=0", o_valid); end
  endtask

  task automatic test_saturation();
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) beat(10000);
    i_valid = 1'b0;
    checks++; if (o_data !== 16'sd32767) begin errors++; $display("FAIL sat_hi_data got=%0d exp=32767", o_data); end
    checks++; if (o_sat !== 1'b1) begin errors++; $display("FAIL sat_hi_flag got=%0b exp=1", o_sat); end
    tick();
    for (int i = 0; i < 5; i++) beat(-20000);
    i_valid = 1'b0;
    checks++; if (o_data !== -16'sd32768) begin errors++; $display("FAIL sat_lo_data got=%0d exp=-32768", o_data); end
    checks++; if (o_sat !== 1'b1) begin errors++; $display("FAIL sat_sticky got=%0b exp=1", o_sat); end
    tick();
  endtask

  task automatic test_back_to_back();
    int v [10] = '{100, -50, 7, 0, 3, 1, 1, 1, 1, 1};
    i_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      beat(v[i]);
      if (i == 1) begin
        checks++; if (o_line !== 3'd2) begin errors++; $display("FAIL b2b_line_mid got=%0d exp=2", o_line); end
      end
      if (i == 4) begin
        checks++; if (o_data !== 16'sd60 || o_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got=%0d/%0b exp=60/1", o_data, o_valid); end
        checks++; if (o_line !== 3'd0) begin errors++; $display("FAIL b2b_line0 got=%0d exp=0", o_line); end
      end
    end
    i_valid = 1'b0;
    checks++; if (o_data !== 16'sd5 || o_valid !== 1'b1) begin errors++; $display("FAIL b2b_second got=%0d/%0b exp=5/1", o_data, o_valid); end
    checks++; if (o_line !== 3'd0) begin errors++; $display("FAIL b2b_line1 got=%0d exp=0", o_line); end
    tick();
  endtask

  task automatic test_full_stall();
    int accepts = 0;
    int pops = 0;
    i_ready = 1'b0;
    for (int i = 0; i < 20; i++) beat(1);
    checks++; if (o_count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", o_count); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b exp=0", o_ready); end
    beat(1);
    beat(1);
    checks++; if (o_line !== 3'd0 || o_count !== 3'd4) begin errors++; $display("FAIL full_stall got=line%0d/cnt%0d exp=0/4", o_line, o_count); end
    i_ready = 1'b1;
    for (int c = 0; c < 40 && pops < 5; c++) begin
      if (i_valid && o_ready) accepts++;
      if (o_valid && i_ready) begin
        pops++;
        checks++; if (o_data !== 16'sd5) begin errors++; $display("FAIL full_drain%0d got=%0d exp=5", pops, o_data); end
      end
      tick();
      if (accepts == 5) i_valid = 1'b0;
    end
    i_valid = 1'b0;
    checks++; if (pops != 5 || accepts != 5) begin errors++; $display("FAIL full_drain_total got=pops%0d/acc%0d exp=5/5", pops, accepts); end
    checks++; if (o_ready !== 1'b1 || o_count !== 3'd0) begin errors++; $display("FAIL full_end got=rdy%0b/cnt%0d exp=1/0", o_ready, o_count); end
  endtask

  task automatic test_simul_push_pop();
    i_ready = 1'b0;
    for (int g = 1; g <= 3; g++)
      for (int i = 0; i < 5; i++) beat(g);
    for (int i = 0; i < 4; i++) beat(4);
    checks++; if (o_count !== 3'd3 || o_data !== 16'sd5) begin errors++; $display("FAIL simul_pre got=cnt%0d/%0d exp=3/5", o_count, o_data); end
    i_ready = 1'b1;
    beat(4);
    i_valid = 1'b0;
    checks++; if (o_count !== 3'd3) begin errors++; $display("FAIL simul_count got=%0d exp=3", o_count); end
    checks++; if (o_data !== 16'sd10) begin errors++; $display("FAIL simul_head got=%0d exp=10", o_data); end
    tick();
    checks++; if (o_data !== 16'sd15) begin errors++; $display("FAIL simul_order2 got=%0d exp=15", o_data); end
    tick();
    checks++; if (o_data !== 16'sd20 || o_valid !== 1'b1) begin errors++; $display("FAIL simul_order3 got=%0d/%0b exp=20/1", o_data, o_valid); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL simul_empty got=%0b exp=0", o_valid); end
  endtask

  task automatic test_clear_and_async_reset();
    i_ready = 1'b0;
    beat(1000);
    beat(1000);
    i_clear = 1'b1;
    beat(777);
    i_clear = 1'b0;
    checks++; if (o_line !== 3'd0 || o_count !== 3'd0) begin errors++; $display("FAIL clear_state got=line%0d/cnt%0d exp=0/0", o_line, o_count); end
    checks++; if (o_sat !== 1'b1) begin errors++; $display("FAIL clear_keeps_sat got=%0b exp=1", o_sat); end
    for (int i = 0; i < 5; i++) beat(2);
    checks++; if (o_count !== 3'd1 || o_data !== 16'sd10) begin errors++; $display("FAIL clear_pixel got=cnt%0d/%0d exp=1/10", o_count, o_data); end
    for (int i = 0; i < 5; i++) beat(3);
    beat(4);
    beat(4);
    i_valid = 1'b0;
    checks++; if (o_count !== 3'd2 || o_data !== 16'sd10) begin errors++; $display("FAIL hold_head got=cnt%0d/%0d exp=2/10", o_count, o_data); end
    checks++; if (o_line !== 3'd2) begin errors++; $display("FAIL pre_rst_line got=%0d exp=2", o_line); end
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin errors++; $display("FAIL async_rst got=%0b/cnt%0d exp=0/0", o_valid, o_count); end
    checks++; if (o_line !== 3'd0 || o_sat !== 1'b0) begin errors++; $display("FAIL async_rst_line got=line%0d/sat%0b exp=0/0", o_line, o_sat); end
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_full_stall();
    test_simul_push_pop();
    test_clear_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
